// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller around an external combinational full adder, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [2:0]       fa_in,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry_q;
    logic [CW-1:0]    count;
    logic             accept, run, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        fa_in   = '0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        run     = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                run   = 1'b1;
                fa_in = {a_sh[0], b_sh[0], carry_q};
                if (count == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sum bits enter at the MSB so after WIDTH steps bit 0 has reached result[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            count   <= '0;
            result  <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_q <= cin;
            count   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (run) begin
            result  <= {fa_sum, result[WIDTH-1:1]};
            carry_q <= fa_carry;
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            count   <= count + CW'(1);
            if (last) begin
                cout <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                ovf  <= carry_q ^ fa_carry;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic reference model plus directed literal cases.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             cin = 1'b0;
    logic [2:0]       fa_in;
    logic             fa_sum, fa_carry;
    logic             busy, done, cout;
    logic [WIDTH-1:0] result;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .fa_in    (fa_in),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    // External combinational full adder
    assign fa_sum   = ^fa_in;
    assign fa_carry = (fa_in[2] & fa_in[1]) | (fa_in[2] & fa_in[0]) | (fa_in[1] & fa_in[0]);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_cyc = cycles since accepted start (0 = idle, WIDTH+1 = done cycle)
    int unsigned      m_cyc = 0;
    logic [31:0]      m_a = '0, m_b = '0, m_c = '0;
    logic [31:0]      m_sum;
    logic [WIDTH-1:0] m_res = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf = 1'b0;

    assign m_sum = m_a + m_b + m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc  <= 0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_cyc == 0) begin
            if (start) begin
                m_cyc <= 1;
                m_a   <= 32'(op_a);
                m_b   <= 32'(op_b);
                m_c   <= 32'(cin);
                m_ovf <= 1'b0;
            end
        end else if (m_cyc == WIDTH + 1) begin
            m_cyc <= 0;
        end else begin
            if (m_cyc == WIDTH) begin
                m_res  <= m_sum[WIDTH-1:0];
                m_cout <= m_sum[WIDTH];
                m_ovf  <= (m_a[WIDTH-1] == m_b[WIDTH-1]) && (m_sum[WIDTH-1] != m_a[WIDTH-1]);
            end
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        logic [2:0]  efa;
        logic [31:0] mask, cr;
        int unsigned k;
        if (rst_n) begin
            efa = '0;
            if (m_cyc >= 1 && m_cyc <= WIDTH) begin
                k    = m_cyc - 1;
                mask = (32'd1 << k) - 32'd1;
                cr   = ((m_a & mask) + (m_b & mask) + m_c) >> k;
                efa  = {m_a[k], m_b[k], cr[0]};
            end
            check("busy", 32'(busy), 32'(m_cyc != 0));
            check("done", 32'(done), 32'(m_cyc == WIDTH + 1));
            check("fa_in", 32'(fa_in), 32'(efa));
            check("cout", 32'(cout), 32'(m_cout));
            if (m_cyc == 0 || m_cyc == WIDTH + 1)
                check("result", 32'(result), 32'(m_res));
`ifdef SERIAL_ADD_OVF_EN
            check("ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    // Issues one add from IDLE and checks latency, busy length and literal result.
    task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                           input logic [WIDTH-1:0] er, input logic ec, input int unsigned poke_at,
                           output logic [2:0] fa0, output logic [2:0] fa1);
        int unsigned n, bc;
        logic seen;
        @(posedge clk); #2;
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); cin = 1'($urandom);
        n = 0; bc = 0; seen = 1'b0; fa0 = '0; fa1 = '0;
        while (!seen && n < WIDTH + 6) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            if (n == 1) fa0 = fa_in;
            if (n == 2) fa1 = fa_in;
            if (done) seen = 1'b1;
            if (poke_at != 0 && n == poke_at) begin
                start = 1'b1; op_a = 8'h11; op_b = 8'h22;
            end
            if (poke_at != 0 && n == poke_at + 1) start = 1'b0;
        end
        start = 1'b0;
        check("latency", n, WIDTH + 1);
        check("busy_len", bc, WIDTH + 1);
        check("lit_result", 32'(result), 32'(er));
        check("lit_cout", 32'(cout), 32'(ec));
    endtask

    initial begin
        logic [2:0] f0, f1;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_fa_in", 32'(fa_in), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0, f0, f1);
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, f0, f1);
        check("fa_first", 32'(f0), 32'(3'b110));
        check("fa_second", 32'(f1), 32'(3'b101));
        run_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, f0, f1);
        run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, f0, f1);
        run_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 3, f0, f1);
        repeat (3) @(negedge clk);
        check("idle_after_poke", 32'(busy), 0);
`ifdef SERIAL_ADD_OVF_EN
        run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, f0, f1);
        check("lit_ovf_set", 32'(ovf), 1);
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, f0, f1);
        check("lit_ovf_clr", 32'(ovf), 0);
`endif

        // Asynchronous reset in the 4th RUN cycle
        @(posedge clk); #2;
        op_a = 8'h35; op_b = 8'h4A; cin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2; rst_n = 1'b0; #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_result", 32'(result), 0);
        check("arst_cout", 32'(cout), 0);
        check("arst_fa_in", 32'(fa_in), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0, f0, f1);

        // Random traffic, including starts while busy and long held starts
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 2) == 0);
            op_a  = WIDTH'($urandom);
            op_b  = WIDTH'($urandom);
            cin   = 1'($urandom);
        end
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #2;
            start = 1'b1;
            op_a  = WIDTH'($urandom);
            op_b  = WIDTH'($urandom);
            cin   = 1'($urandom);
        end
        @(posedge clk); #2;
        start = 1'b0;
        repeat (WIDTH + 4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
